memory_responder: RTL and testbench
===================================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 17: byte address width of both request ports.
REQ-002 Parameter LEN, default 32: data word width.
REQ-003 Parameter MEM_DEPTH, default 4096: number of LEN-bit words stored.
REQ-004 Parameter LATENCY, default 3, legal range 1..15: number of WORKING cycles before an access completes.
REQ-005 clk  input  1: single clock; all state updates on the rising edge.
REQ-006 rst  input  1: asynchronous, active-high reset.
REQ-007 inst_vis_addr  input  ADDR_WIDTH: instruction-side byte address.
REQ-008 inst_vis_signal  input  2: instruction-side request; 00 NOP, 01 READ; 10 and 11 are treated as NOP.
REQ-009 inst_mem_data  output  LEN: instruction-side read data.
REQ-010 inst_mem_status  output  2: instruction-side status; 00 MEM_RESTING, 01 MEM_WORKING, 10 MEM_FINISHED.
REQ-011 data_vis_addr  input  ADDR_WIDTH: data-side byte address.
REQ-012 data_vis_signal  input  2: data-side request; 00 NOP, 01 READ, 10 WRITE; 11 is treated as NOP.
REQ-013 data_write_data  input  LEN: data-side write word.
REQ-014 data_write_mask  input  LEN/8: per-byte write enable; bit i enables byte i.
REQ-015 data_mem_data  output  LEN: data-side read data.
REQ-016 data_mem_status  output  2: data-side status, same encoding as REQ-010.

Function
REQ-017 Word index SHALL be (addr >> 2) mod MEM_DEPTH; address bits [1:0] SHALL be ignored, and out-of-range addresses SHALL wrap.
REQ-018 FSM states SHALL be IDLE, BUSY and DONE; only one access SHALL be in flight at a time.
REQ-019 In IDLE, a data-side READ or WRITE SHALL be granted at the rising edge; otherwise an instruction-side READ SHALL be granted; otherwise the FSM SHALL stay in IDLE.
REQ-020 Data side SHALL win when both ports request at the same edge.
REQ-021 At grant the FSM SHALL latch port, op, word index, write data and mask, load the counter with LATENCY, and enter BUSY.
REQ-022 In BUSY the counter SHALL decrement by 1 per edge; on the edge where it reaches 0, the FSM SHALL perform the access and enter DONE.
REQ-023 A READ SHALL load the latched word into the granted port's mem_data register.
REQ-024 A WRITE SHALL update only the bytes enabled in the mask; a WRITE SHALL leave data_mem_data unchanged.
REQ-025 DONE SHALL last exactly one cycle and then return to IDLE; requests present during DONE SHALL NOT be granted until the IDLE edge that follows.
REQ-026 Granted port's status SHALL be MEM_WORKING for exactly LATENCY cycles after the grant, then MEM_FINISHED for the single DONE cycle.
REQ-027 Non-granted port's status SHALL be MEM_WORKING whenever its signal is non-NOP while the FSM is not idle or the other port wins arbitration; otherwise it SHALL be MEM_RESTING.
REQ-028 In IDLE, each status SHALL be MEM_RESTING.
REQ-029 mem_data outputs SHALL hold their last read value until the next READ completes on the same port.
REQ-030 Input changes after grant SHALL NOT affect the in-flight access.
REQ-031 A requester SHALL hold its signal until it sees MEM_FINISHED; a request withdrawn while stalled SHALL be lost and SHALL NOT be treated as an error.

Reset
REQ-032 While rst=1: state IDLE, counter 0, both statuses MEM_RESTING, both mem_data outputs 0.
REQ-033 Reset SHALL NOT alter memory array contents.
REQ-034 Reset asserted in BUSY SHALL abort the access; a pending WRITE SHALL NOT be performed.

Verification
REQ-035 Preload word 5 = 0xDEADBEEF, LATENCY=3; inst READ addr 0x14 -> inst_mem_status WORKING for 3 cycles, FINISHED for 1 cycle with inst_mem_data=0xDEADBEEF, then RESTING.
REQ-036 Data WRITE addr 0x20, data 0x11223344, mask 0101 over an old word 0xAABBCCDD, then data READ 0x20 -> data_mem_data=0xAA22CC44.
REQ-037 Inst READ and data READ asserted at the same edge -> data side served first; inst side sees WORKING through data's BUSY and DONE plus its own 3 cycles, then FINISHED with correct word.
REQ-038 Inst READ addr 0x4000 with MEM_DEPTH=4096 -> returns word 0 (wrap).
REQ-039 Data WRITE issued, rst pulsed on 2nd BUSY cycle -> both statuses RESTING immediately; subsequent READ of that address returns the pre-write value.
REQ-040 Back-to-back inst READs with signal held -> one idle cycle between FINISHED and the next WORKING, and each FINISHED carries the correct word.

Source files
------------

// File: rtl/memory_responder_if.sv
// Request/response bundle between one requester pair (instruction and data side)
// and the memory responder.
interface memory_responder_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32
);
  logic [ADDR_WIDTH-1:0] inst_vis_addr;
  logic [1:0]            inst_vis_signal;
  logic [LEN-1:0]        inst_mem_data;
  logic [1:0]            inst_mem_status;

  logic [ADDR_WIDTH-1:0] data_vis_addr;
  logic [1:0]            data_vis_signal;
  logic [LEN-1:0]        data_write_data;
  logic [LEN/8-1:0]      data_write_mask;
  logic [LEN-1:0]        data_mem_data;
  logic [1:0]            data_mem_status;

  modport master (
    output inst_vis_addr, inst_vis_signal,
    input  inst_mem_data, inst_mem_status,
    output data_vis_addr, data_vis_signal, data_write_data, data_write_mask,
    input  data_mem_data, data_mem_status
  );

  modport slave (
    input  inst_vis_addr, inst_vis_signal,
    output inst_mem_data, inst_mem_status,
    input  data_vis_addr, data_vis_signal, data_write_data, data_write_mask,
    output data_mem_data, data_mem_status
  );
endinterface

// File: rtl/memory_responder.sv
// Shared single-port memory serving an instruction port and a data port, one
// access at a time with a fixed latency; data side has priority.
module memory_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32,
  parameter int MEM_DEPTH  = 4096,
  parameter int LATENCY    = 3
) (
  input logic               clk,
  input logic               rst,
  memory_responder_if.slave bus_if
);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int LANES = LEN / 8;

  localparam logic [1:0] SIG_READ     = 2'b01;
  localparam logic [1:0] SIG_WRITE    = 2'b10;
  localparam logic [1:0] MEM_RESTING  = 2'b00;
  localparam logic [1:0] MEM_WORKING  = 2'b01;
  localparam logic [1:0] MEM_FINISHED = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'(64'(addr >> 2) % 64'(MEM_DEPTH));
  endfunction

  function automatic logic [1:0] waiting_status(input logic req);
    return req ? MEM_WORKING : MEM_RESTING;
  endfunction

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic             port_data_q;
  logic             op_write_q;
  logic [IDX_W-1:0] idx_q;
  logic [LEN-1:0]   wdata_q;
  logic [LANES-1:0] mask_q;
  logic [LEN-1:0]   inst_data_q;
  logic [LEN-1:0]   data_data_q;
  logic [1:0]       inst_status_q;
  logic [1:0]       data_status_q;

  logic             inst_req;
  logic             data_req;
  logic [IDX_W-1:0] inst_idx;
  logic [IDX_W-1:0] data_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             access_now;
  logic             do_write;
  logic [LEN-1:0]   rd_word;

  assign inst_req   = (bus_if.inst_vis_signal == SIG_READ);
  assign data_req   = (bus_if.data_vis_signal == SIG_READ) || (bus_if.data_vis_signal == SIG_WRITE);
  assign inst_idx   = word_index(bus_if.inst_vis_addr);
  assign data_idx   = word_index(bus_if.data_vis_addr);
  assign access_now = (state_q == BUSY) && (cnt_q <= 4'd1);
  assign do_write   = access_now && op_write_q;

  // Read port tracks the index being granted so the word is already registered
  // by the completion edge, even when LATENCY is 1.
  assign rd_idx = (state_q == IDLE) ? (data_req ? data_idx : inst_idx) : idx_q;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] lane_mem [MEM_DEPTH];
      logic [7:0] lane_rd_q;

      always_ff @(posedge clk) begin
        if (do_write && mask_q[gi]) begin
          lane_mem[idx_q] <= wdata_q[gi*8 +: 8];
        end
        lane_rd_q <= lane_mem[rd_idx];
      end

      assign rd_word[gi*8 +: 8] = lane_rd_q;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      port_data_q   <= 1'b0;
      op_write_q    <= 1'b0;
      idx_q         <= '0;
      wdata_q       <= '0;
      mask_q        <= '0;
      inst_data_q   <= '0;
      data_data_q   <= '0;
      inst_status_q <= MEM_RESTING;
      data_status_q <= MEM_RESTING;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_req) begin
            state_q       <= BUSY;
            cnt_q         <= 4'(LATENCY);
            port_data_q   <= 1'b1;
            op_write_q    <= (bus_if.data_vis_signal == SIG_WRITE);
            idx_q         <= data_idx;
            wdata_q       <= bus_if.data_write_data;
            mask_q        <= bus_if.data_write_mask;
            data_status_q <= MEM_WORKING;
            inst_status_q <= waiting_status(inst_req);
          end else if (inst_req) begin
            state_q       <= BUSY;
            cnt_q         <= 4'(LATENCY);
            port_data_q   <= 1'b0;
            op_write_q    <= 1'b0;
            idx_q         <= inst_idx;
            inst_status_q <= MEM_WORKING;
            data_status_q <= MEM_RESTING;
          end else begin
            inst_status_q <= MEM_RESTING;
            data_status_q <= MEM_RESTING;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (access_now) begin
            state_q <= DONE;
          end
          if (port_data_q) begin
            data_status_q <= access_now ? MEM_FINISHED : MEM_WORKING;
            inst_status_q <= waiting_status(inst_req);
            if (access_now && !op_write_q) begin
              data_data_q <= rd_word;
            end
          end else begin
            inst_status_q <= access_now ? MEM_FINISHED : MEM_WORKING;
            data_status_q <= waiting_status(data_req);
            if (access_now) begin
              inst_data_q <= rd_word;
            end
          end
        end
        DONE: begin
          state_q       <= IDLE;
          inst_status_q <= MEM_RESTING;
          data_status_q <= MEM_RESTING;
        end
        default: begin
          state_q       <= IDLE;
          inst_status_q <= MEM_RESTING;
          data_status_q <= MEM_RESTING;
        end
      endcase
    end
  end

  assign bus_if.inst_mem_data   = inst_data_q;
  assign bus_if.inst_mem_status = inst_status_q;
  assign bus_if.data_mem_data   = data_data_q;
  assign bus_if.data_mem_status = data_status_q;
endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: directed scenarios plus random
// accesses checked against a word-array model of the memory.
module tb_memory_responder;
  localparam int AW    = 17;
  localparam int LEN   = 32;
  localparam int DEPTH = 4096;
  localparam int LAT   = 3;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_inst_data;
  logic [31:0] exp_data_data;

  memory_responder_if #(.ADDR_WIDTH(AW), .LEN(LEN)) bus_if ();

  memory_responder #(
    .ADDR_WIDTH(AW), .LEN(LEN), .MEM_DEPTH(DEPTH), .LATENCY(LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required summary before limit");
    $fatal(1);
  end

  function automatic int widx(input logic [AW-1:0] a);
    return (int'(a) >> 2) % DEPTH;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] bm;
    bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (old_w & ~bm) | (new_w & bm);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access from an idle responder, checking the status timeline,
  // the returned word, and that the other port's data register is untouched.
  task automatic do_access(input bit is_data, input bit is_write, input logic [AW-1:0] addr,
                           input logic [31:0] wd, input logic [3:0] m, input string tag);
    int          idx;
    logic [1:0]  st;
    logic [1:0]  other_st;
    logic [1:0]  nop_codes [3];
    idx = widx(addr);
    nop_codes[0] = 2'b00; nop_codes[1] = 2'b10; nop_codes[2] = 2'b11;
    if (is_data) begin
      bus_if.data_vis_signal = is_write ? 2'b10 : 2'b01;
      bus_if.data_vis_addr   = addr;
      bus_if.data_write_data = wd;
      bus_if.data_write_mask = m;
      bus_if.inst_vis_signal = nop_codes[$urandom_range(0, 2)];
    end else begin
      bus_if.inst_vis_signal = 2'b01;
      bus_if.inst_vis_addr   = addr;
      bus_if.data_vis_signal = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    end
    tick();
    // Address/data may wander once granted; the access must not notice.
    bus_if.data_vis_addr   = AW'($urandom);
    bus_if.data_write_data = $urandom;
    bus_if.data_write_mask = 4'($urandom);
    bus_if.inst_vis_addr   = AW'($urandom);
    for (int i = 0; i < LAT; i++) begin
      st = is_data ? bus_if.data_mem_status : bus_if.inst_mem_status;
      n_checks++;
      if (st !== 2'b01) begin
        n_fail++;
        $display("FAIL %s working[%0d]: status got %0d required 1", tag, i, st);
      end
      tick();
    end
    if (is_write) model_mem[idx] = merge(model_mem[idx], wd, m);
    else if (is_data) exp_data_data = model_mem[idx];
    else exp_inst_data = model_mem[idx];
    st       = is_data ? bus_if.data_mem_status : bus_if.inst_mem_status;
    other_st = is_data ? bus_if.inst_mem_status : bus_if.data_mem_status;
    n_checks++;
    if (st !== 2'b10) begin
      n_fail++;
      $display("FAIL %s finished: status got %0d required 2", tag, st);
    end
    n_checks++;
    if (other_st !== 2'b00) begin
      n_fail++;
      $display("FAIL %s other_port: status got %0d required 0", tag, other_st);
    end
    n_checks++;
    if (bus_if.inst_mem_data !== exp_inst_data) begin
      n_fail++;
      $display("FAIL %s inst_data: got %h required %h", tag, bus_if.inst_mem_data, exp_inst_data);
    end
    n_checks++;
    if (bus_if.data_mem_data !== exp_data_data) begin
      n_fail++;
      $display("FAIL %s data_data: got %h required %h", tag, bus_if.data_mem_data, exp_data_data);
    end
    bus_if.inst_vis_signal = 2'b00;
    bus_if.data_vis_signal = 2'b00;
    tick();
    st = is_data ? bus_if.data_mem_status : bus_if.inst_mem_status;
    n_checks++;
    if (st !== 2'b00) begin
      n_fail++;
      $display("FAIL %s resting: status got %0d required 0", tag, st);
    end
    $display("txn %s: %s %s addr=%h idx=%0d wd=%h mask=%b inst_data=%h data_data=%h", tag,
             is_data ? "data" : "inst", is_write ? "WR" : "RD", addr, idx, wd, m,
             bus_if.inst_mem_data, bus_if.data_mem_data);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks += 4;
    if (bus_if.inst_mem_status !== 2'b00) begin
      n_fail++; $display("FAIL reset inst_status: got %0d required 0", bus_if.inst_mem_status);
    end
    if (bus_if.data_mem_status !== 2'b00) begin
      n_fail++; $display("FAIL reset data_status: got %0d required 0", bus_if.data_mem_status);
    end
    if (bus_if.inst_mem_data !== 32'h0) begin
      n_fail++; $display("FAIL reset inst_data: got %h required 0", bus_if.inst_mem_data);
    end
    if (bus_if.data_mem_data !== 32'h0) begin
      n_fail++; $display("FAIL reset data_data: got %h required 0", bus_if.data_mem_data);
    end
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus_if.inst_mem_status !== 2'b00 || bus_if.data_mem_status !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_status: got %0d/%0d required 0/0", bus_if.inst_mem_status, bus_if.data_mem_status);
    end
    $display("txn reset: statuses and data checked");
  endtask

  // Fill words 0..15 through aliased addresses (upper copies and low byte bits).
  task automatic test_init();
    logic [AW-1:0] a;
    for (int w = 0; w < 16; w++) begin
      a = AW'((w + DEPTH * $urandom_range(0, 7)) * 4 + $urandom_range(0, 3));
      do_access(1'b1, 1'b1, a, $urandom, 4'hF, "init");
    end
  endtask

  task automatic test_preload_read();
    do_access(1'b1, 1'b1, 17'h14, 32'hDEADBEEF, 4'hF, "preload");
    do_access(1'b0, 1'b0, 17'h14, 32'h0, 4'h0, "inst_rd5");
    n_checks++;
    if (bus_if.inst_mem_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL inst_rd5 value: got %h required deadbeef", bus_if.inst_mem_data);
    end
  endtask

  task automatic test_masked_write();
    do_access(1'b1, 1'b1, 17'h20, 32'hAABBCCDD, 4'hF, "old_word");
    do_access(1'b1, 1'b1, 17'h20, 32'h11223344, 4'b0101, "mask_wr");
    do_access(1'b1, 1'b0, 17'h20, 32'h0, 4'h0, "mask_rd");
    n_checks++;
    if (bus_if.data_mem_data !== 32'hAA22CC44) begin
      n_fail++; $display("FAIL mask_rd value: got %h required aa22cc44", bus_if.data_mem_data);
    end
  endtask

  task automatic test_wrap();
    do_access(1'b0, 1'b0, 17'h4000, 32'h0, 4'h0, "wrap_rd");
    n_checks++;
    if (bus_if.inst_mem_data !== model_mem[0]) begin
      n_fail++; $display("FAIL wrap word0: got %h required %h", bus_if.inst_mem_data, model_mem[0]);
    end
    do_access(1'b0, 1'b0, 17'h17, 32'h0, 4'h0, "low_bits_rd");
  endtask

  task automatic test_arbitration();
    bus_if.inst_vis_signal = 2'b01;
    bus_if.inst_vis_addr   = 17'h28;
    bus_if.data_vis_signal = 2'b01;
    bus_if.data_vis_addr   = 17'h2C;
    tick();
    for (int i = 0; i < LAT; i++) begin
      n_checks++;
      if (bus_if.data_mem_status !== 2'b01 || bus_if.inst_mem_status !== 2'b01) begin
        n_fail++;
        $display("FAIL arb busy[%0d]: data/inst status got %0d/%0d required 1/1", i,
                 bus_if.data_mem_status, bus_if.inst_mem_status);
      end
      tick();
    end
    exp_data_data = model_mem[11];
    n_checks++;
    if (bus_if.data_mem_status !== 2'b10 || bus_if.inst_mem_status !== 2'b01 ||
        bus_if.data_mem_data !== exp_data_data) begin
      n_fail++;
      $display("FAIL arb data_done: status %0d/%0d data %h required 2/1 %h", bus_if.data_mem_status,
               bus_if.inst_mem_status, bus_if.data_mem_data, exp_data_data);
    end
    bus_if.data_vis_signal = 2'b00;
    tick();
    n_checks++;
    if (bus_if.inst_mem_status !== 2'b00 || bus_if.data_mem_status !== 2'b00) begin
      n_fail++;
      $display("FAIL arb idle_gap: status %0d/%0d required 0/0", bus_if.inst_mem_status, bus_if.data_mem_status);
    end
    tick();
    for (int i = 0; i < LAT; i++) begin
      n_checks++;
      if (bus_if.inst_mem_status !== 2'b01) begin
        n_fail++; $display("FAIL arb inst_busy[%0d]: got %0d required 1", i, bus_if.inst_mem_status);
      end
      tick();
    end
    exp_inst_data = model_mem[10];
    n_checks++;
    if (bus_if.inst_mem_status !== 2'b10 || bus_if.inst_mem_data !== exp_inst_data) begin
      n_fail++;
      $display("FAIL arb inst_done: status %0d data %h required 2 %h", bus_if.inst_mem_status,
               bus_if.inst_mem_data, exp_inst_data);
    end
    bus_if.inst_vis_signal = 2'b00;
    tick();
    $display("txn arbitration: data idx11=%h then inst idx10=%h", exp_data_data, exp_inst_data);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [3];
    addrs[0] = 17'h0C; addrs[1] = 17'h3C; addrs[2] = 17'h1C;
    bus_if.inst_vis_signal = 2'b01;
    bus_if.inst_vis_addr   = addrs[0];
    tick();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < LAT; i++) begin
        n_checks++;
        if (bus_if.inst_mem_status !== 2'b01) begin
          n_fail++; $display("FAIL b2b[%0d] busy[%0d]: got %0d required 1", k, i, bus_if.inst_mem_status);
        end
        tick();
      end
      exp_inst_data = model_mem[widx(addrs[k])];
      n_checks++;
      if (bus_if.inst_mem_status !== 2'b10 || bus_if.inst_mem_data !== exp_inst_data) begin
        n_fail++;
        $display("FAIL b2b[%0d] done: status %0d data %h required 2 %h", k, bus_if.inst_mem_status,
                 bus_if.inst_mem_data, exp_inst_data);
      end
      if (k < 2) bus_if.inst_vis_addr = addrs[k+1];
      else bus_if.inst_vis_signal = 2'b00;
      tick();
      n_checks++;
      if (bus_if.inst_mem_status !== 2'b00) begin
        n_fail++; $display("FAIL b2b[%0d] gap: got %0d required 0", k, bus_if.inst_mem_status);
      end
      if (k < 2) tick();
      $display("txn b2b[%0d]: inst RD addr=%h data=%h", k, addrs[k], exp_inst_data);
    end
  endtask

  task automatic test_reset_abort();
    do_access(1'b1, 1'b1, 17'h30, 32'h5A5A1234, 4'hF, "abort_pre");
    bus_if.data_vis_signal = 2'b10;
    bus_if.data_vis_addr   = 17'h30;
    bus_if.data_write_data = 32'h0BADF00D;
    bus_if.data_write_mask = 4'hF;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    exp_inst_data = 32'h0;
    exp_data_data = 32'h0;
    n_checks += 2;
    if (bus_if.inst_mem_status !== 2'b00 || bus_if.data_mem_status !== 2'b00) begin
      n_fail++;
      $display("FAIL abort status: got %0d/%0d required 0/0", bus_if.inst_mem_status, bus_if.data_mem_status);
    end
    if (bus_if.inst_mem_data !== 32'h0 || bus_if.data_mem_data !== 32'h0) begin
      n_fail++;
      $display("FAIL abort data: got %h/%h required 0/0", bus_if.inst_mem_data, bus_if.data_mem_data);
    end
    bus_if.data_vis_signal = 2'b00;
    tick();
    rst = 1'b0;
    tick();
    do_access(1'b1, 1'b0, 17'h30, 32'h0, 4'h0, "abort_rd");
    n_checks++;
    if (bus_if.data_mem_data !== 32'h5A5A1234) begin
      n_fail++; $display("FAIL abort_rd value: got %h required 5a5a1234", bus_if.data_mem_data);
    end
  endtask

  task automatic test_random();
    bit            is_data;
    bit            is_write;
    logic [AW-1:0] a;
    for (int n = 0; n < 30; n++) begin
      is_data  = 1'($urandom_range(0, 1));
      is_write = is_data && ($urandom_range(0, 1) == 1);
      a = AW'(($urandom_range(0, 15) + DEPTH * $urandom_range(0, 7)) * 4 + $urandom_range(0, 3));
      do_access(is_data, is_write, a, $urandom, 4'($urandom), "rand");
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_if.inst_vis_addr   = '0;
    bus_if.inst_vis_signal = 2'b00;
    bus_if.data_vis_addr   = '0;
    bus_if.data_vis_signal = 2'b00;
    bus_if.data_write_data = '0;
    bus_if.data_write_mask = '0;
    exp_inst_data = 32'h0;
    exp_data_data = 32'h0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    test_reset();
    test_init();
    test_preload_read();
    test_masked_write();
    test_wrap();
    test_arbitration();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
